// File: rtl/monopix_out_fifo.sv
// First-word-fall-through output buffer between the readout arbiter and the host FIFO reader.
// Optional feature: define OUT_FIFO_WATERMARK_EN to add the FIFO_MAX_SIZE high-water-mark output.
module monopix_out_fifo #(
  parameter int DEPTH_LOG2          = 10,
  parameter int NEAR_FULL_THRESHOLD = 1000
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST_N,
  input  logic                  FLUSH,
  input  logic                  ARB_WRITE_IN,
  input  logic [31:0]           ARB_DATA_IN,
  output logic                  ARB_READY,
  input  logic                  FIFO_READ_NEXT,
  output logic                  FIFO_EMPTY,
  output logic [31:0]           FIFO_DATA,
  output logic                  FIFO_FULL,
  output logic                  FIFO_NEAR_FULL,
  output logic [DEPTH_LOG2:0]   FIFO_SIZE,
`ifdef OUT_FIFO_WATERMARK_EN
  output logic [DEPTH_LOG2:0]   FIFO_MAX_SIZE,
`endif
  output logic [7:0]            LOST_CNT
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   NF_LVL   = NEAR_FULL_THRESHOLD[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   SIZE_ONE = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   size_q, size_d;
  logic                  empty_q, empty_d, full_q, full_d, nfull_q, nfull_d;
  logic [7:0]            lost_q, lost_d;
  logic [31:0]           data_q, data_d;
  logic                  run_q;
  logic                  wr_acc, wr_drop, rd_acc;

  assign wr_acc  = ARB_WRITE_IN & run_q & ~full_q & ~FLUSH;
  assign wr_drop = ARB_WRITE_IN & run_q &  full_q & ~FLUSH;
  assign rd_acc  = FIFO_READ_NEXT & ~empty_q & ~FLUSH;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    size_d   = size_q;
    lost_d   = lost_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      size_d   = '0;
      lost_d   = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   size_d = size_q + SIZE_ONE;
        2'b01:   size_d = size_q - SIZE_ONE;
        default: size_d = size_q;
      endcase
      if (wr_drop && lost_q != 8'hFF) lost_d = lost_q + 8'd1;
    end
    empty_d = (size_d == '0);
    full_d  = (size_d == FULL_LVL);
    nfull_d = (size_d >= NF_LVL);
    // Prefetch the next head; bypass the memory when the new head is the word being written now.
    if (wr_acc && wr_ptr_q == rd_ptr_d) data_d = ARB_DATA_IN;
    else                                data_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge BUS_CLK) begin
    if (wr_acc) mem_q[wr_ptr_q] <= ARB_DATA_IN;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      run_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      size_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      nfull_q  <= 1'b0;
      lost_q   <= '0;
      data_q   <= '0;
    end else begin
      run_q    <= 1'b1;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      size_q   <= size_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      nfull_q  <= nfull_d;
      lost_q   <= lost_d;
      data_q   <= data_d;
    end
  end

`ifdef OUT_FIFO_WATERMARK_EN
  logic [DEPTH_LOG2:0] max_q;

  // Tracks the registered fill level, so the mark lags FIFO_SIZE by one cycle.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N)           max_q <= '0;
    else if (FLUSH)           max_q <= '0;
    else if (size_q > max_q)  max_q <= size_q;
  end

  assign FIFO_MAX_SIZE = max_q;
`endif

  assign ARB_READY      = run_q & ~full_q;
  assign FIFO_EMPTY     = empty_q;
  assign FIFO_DATA      = data_q;
  assign FIFO_FULL      = full_q;
  assign FIFO_NEAR_FULL = nfull_q;
  assign FIFO_SIZE      = size_q;
  assign LOST_CNT       = lost_q;

endmodule

// File: tb/tb_monopix_out_fifo.sv
// Scoreboard bench for monopix_out_fifo with DEPTH_LOG2=4, NEAR_FULL_THRESHOLD=12.
module tb_monopix_out_fifo;

  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr = 1'b0;
  logic [31:0]   wdata = '0;
  logic          ready;
  logic          rd = 1'b0;
  logic          empty;
  logic [31:0]   rdata;
  logic          full;
  logic          nfull;
  logic [DL:0]   size;
  logic [7:0]    lost;
`ifdef OUT_FIFO_WATERMARK_EN
  logic [DL:0]   max_size;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  monopix_out_fifo #(.DEPTH_LOG2(DL), .NEAR_FULL_THRESHOLD(12)) dut (
    .BUS_CLK        (clk),
    .BUS_RST_N      (rst_n),
    .FLUSH          (flush),
    .ARB_WRITE_IN   (wr),
    .ARB_DATA_IN    (wdata),
    .ARB_READY      (ready),
    .FIFO_READ_NEXT (rd),
    .FIFO_EMPTY     (empty),
    .FIFO_DATA      (rdata),
    .FIFO_FULL      (full),
    .FIFO_NEAR_FULL (nfull),
    .FIFO_SIZE      (size),
`ifdef OUT_FIFO_WATERMARK_EN
    .FIFO_MAX_SIZE  (max_size),
`endif
    .LOST_CNT       (lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " empty"}, {31'd0, empty}, 32'd1);
    check({tag, " full"},  {31'd0, full},  32'd0);
    check({tag, " nfull"}, {31'd0, nfull}, 32'd0);
    check({tag, " size"},  {27'd0, size},  32'd0);
    check({tag, " lost"},  {24'd0, lost},  32'd0);
    check({tag, " ready"}, {31'd0, ready}, 32'd0);
    check({tag, " data"},  rdata,          32'd0);
  endtask

  // Monitor: every accepted read pops the scoreboard and compares the head word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rd && !empty) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL read_unexpected: got %h, want no word", rdata);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (rdata !== e) begin
            bad++;
            $display("FAIL read_data: got %h, want %h at %0t", rdata, e, $time);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and start-up
    #12;
    check_reset_vals("reset");
    rst_n = 1'b1;
    #1;
    check("ready_before_run", {31'd0, ready}, 32'd0);
    step();
    check("ready_after_run", {31'd0, ready}, 32'd1);
    check("empty_after_run", {31'd0, empty}, 32'd1);
    check("size_after_run",  {27'd0, size},  32'd0);

    // Single word
    wr = 1'b1; wdata = 32'hDEADBEEF; exp_q.push_back(32'hDEADBEEF);
    step();
    wr = 1'b0;
    check("single_data",  rdata,          32'hDEADBEEF);
    check("single_empty", {31'd0, empty}, 32'd0);
    check("single_size",  {27'd0, size},  32'd1);
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("single_empty_after_rd", {31'd0, empty}, 32'd1);
    check("single_size_after_rd",  {27'd0, size},  32'd0);

    // Fill and overflow
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; wdata = i; exp_q.push_back(i);
      step();
      check($sformatf("fill_size_%0d", i),  {27'd0, size},  i + 1);
      check($sformatf("fill_nfull_%0d", i), {31'd0, nfull}, (i + 1 >= 12) ? 32'd1 : 32'd0);
      check($sformatf("fill_full_%0d", i),  {31'd0, full},  (i + 1 == 16) ? 32'd1 : 32'd0);
      check($sformatf("fill_ready_%0d", i), {31'd0, ready}, (i + 1 == 16) ? 32'd0 : 32'd1);
    end
    for (int k = 0; k < 3; k++) begin
      wdata = 32'h100 + k;
      step();
    end
    wr = 1'b0;
    check("overflow_lost", {24'd0, lost}, 32'd3);
    check("overflow_size", {27'd0, size}, 32'd16);
`ifdef OUT_FIFO_WATERMARK_EN
    step();
    check("watermark_max", {27'd0, max_size}, 32'd16);
`endif
    rd = 1'b1;
    for (int i = 0; i < 16; i++) step();
    rd = 1'b0;
    check("drain_empty", {31'd0, empty}, 32'd1);
    check("drain_size",  {27'd0, size},  32'd0);
    check("drain_queue", exp_q.size(),   32'd0);

    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_clears_lost", {24'd0, lost}, 32'd0);

    // Streaming with wrap
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; wdata = 32'h200 + i; exp_q.push_back(32'h200 + i);
      step();
    end
    check("stream_pre_size", {27'd0, size}, 32'd5);
    rd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wdata = 32'h300 + i; exp_q.push_back(32'h300 + i);
      step();
      if (size != 5) check($sformatf("stream_size_%0d", i), {27'd0, size}, 32'd5);
    end
    check("stream_size", {27'd0, size}, 32'd5);
    wr = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rd = 1'b0;
    check("stream_lost",  {24'd0, lost},  32'd0);
    check("stream_empty", {31'd0, empty}, 32'd1);
    check("stream_queue", exp_q.size(),   32'd0);

    // FLUSH collision
    for (int i = 0; i < 7; i++) begin
      wr = 1'b1; wdata = 32'h400 + i; exp_q.push_back(32'h400 + i);
      step();
    end
    wr = 1'b0;
    check("pre_flush_size", {27'd0, size}, 32'd7);
    flush = 1'b1; wr = 1'b1; wdata = 32'hBAD0BAD0; rd = 1'b1;
    step();
    flush = 1'b0; wr = 1'b0; rd = 1'b0;
    exp_q.delete();
    check("flush_size",  {27'd0, size},  32'd0);
    check("flush_empty", {31'd0, empty}, 32'd1);
    check("flush_lost",  {24'd0, lost},  32'd0);
    rd = 1'b1;
    step();
    rd = 1'b0;
    check("rd_empty_size",  {27'd0, size},  32'd0);
    check("rd_empty_empty", {31'd0, empty}, 32'd1);

    // Saturation and asynchronous reset
    wr = 1'b1;
    for (int i = 0; i < 316; i++) begin
      wdata = 32'h500 + i;
      step();
    end
    wr = 1'b0;
    check("sat_full", {31'd0, full}, 32'd1);
    check("sat_lost", {24'd0, lost}, 32'd255);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    #10;
    rst_n = 1'b1;
    step();
    check("post_reset_empty", {31'd0, empty}, 32'd1);
    check("post_reset_ready", {31'd0, ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
